// File: rtl/jtvigil_obj_linebuf.sv
// Double-buffered object line buffer: the drawer fills one bank while the mixer reads and erases the other.
// Build option JTVIGIL_OBJLB_PRIO_EN: per-location occupancy flags so the first opaque pixel drawn wins.
module jtvigil_obj_linebuf #(
  parameter int unsigned AW    = 9,
  parameter int unsigned DW    = 8,
  parameter logic [3:0]  ALPHA = 4'h0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          LHBL,
  input  logic          flip,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          we,
  input  logic [AW-1:0] rd_addr,
  input  logic          rd,
  output logic [DW-1:0] rd_data,
  output logic          init_done
);

  localparam logic [DW-1:0] FILL  = {{(DW-4){1'b0}}, ALPHA};
  localparam int unsigned   DEPTH = 2**AW;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        state_q;
  logic [AW-1:0] cnt_q;
  logic          init_done_q;
  logic          wbank_q;
  logic          lhbl_l_q;
  logic [DW-1:0] rd_data_q;
  logic          erase_q;
  logic [AW-1:0] ra_l_q;
  logic          ebank_q;

  logic [DW-1:0] mem_q [2][DEPTH];

  logic [AW-1:0] ra_s;
  logic          rbank_s;
  logic          swap_s;
  logic          draw_ok_s;
  logic [1:0]    wen_s;
  logic [AW-1:0] waddr_s [2];
  logic [DW-1:0] wdata_s [2];

  assign ra_s    = flip ? ~rd_addr : rd_addr;
  assign rbank_s = ~wbank_q;
  assign swap_s  = LHBL & ~lhbl_l_q;

`ifdef JTVIGIL_OBJLB_PRIO_EN
  logic [DEPTH-1:0] flag_q [2];

  assign draw_ok_s = we && (wr_data[3:0] != ALPHA) && !flag_q[wbank_q][wr_addr];

  // Occupancy flags follow every RAM write: opaque data sets, fill (erase/sweep) clears
  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (wen_s[b]) begin
        flag_q[b][waddr_s[b]] <= (wdata_s[b][3:0] != ALPHA);
      end
    end
  end
`else
  assign draw_ok_s = we && (wr_data[3:0] != ALPHA);
`endif

  // Per-bank write port mux. Normally the erase and drawer target different banks;
  // only the cycle after a swap that coincided with a read can they meet, and the erase wins.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      wen_s[b]   = 1'b0;
      waddr_s[b] = wr_addr;
      wdata_s[b] = wr_data;
      if (state_q == ST_INIT) begin
        wen_s[b]   = 1'b1;
        waddr_s[b] = cnt_q;
        wdata_s[b] = FILL;
      end else if (erase_q && (ebank_q == 1'(b))) begin
        wen_s[b]   = 1'b1;
        waddr_s[b] = ra_l_q;
        wdata_s[b] = FILL;
      end else if (draw_ok_s && (wbank_q == 1'(b))) begin
        wen_s[b]   = 1'b1;
        waddr_s[b] = wr_addr;
        wdata_s[b] = wr_data;
      end else begin
        wen_s[b]   = 1'b0;
      end
    end
  end

  // Bank RAM write ports (contents are never reset; the sweep clears them)
  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (wen_s[b]) begin
        mem_q[b][waddr_s[b]] <= wdata_s[b];
      end
    end
  end

  // Control FSM: clear sweep, bank swapping, registered read and erase bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= {AW{1'b0}};
      init_done_q <= 1'b0;
      wbank_q     <= 1'b0;
      lhbl_l_q    <= 1'b0;
      rd_data_q   <= FILL;
      erase_q     <= 1'b0;
      ra_l_q      <= {AW{1'b0}};
      ebank_q     <= 1'b0;
    end else begin
      lhbl_l_q <= LHBL;
      case (state_q)
        ST_INIT: begin
          cnt_q   <= cnt_q + AW'(1);
          erase_q <= 1'b0;
          if (cnt_q == {AW{1'b1}}) begin
            init_done_q <= 1'b1;
            state_q     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (swap_s) begin
            wbank_q <= ~wbank_q;
          end
          // Erase target bank is latched here so a simultaneous swap cannot redirect it
          erase_q <= rd;
          ra_l_q  <= ra_s;
          ebank_q <= rbank_s;
          if (rd) begin
            rd_data_q <= mem_q[rbank_s][ra_s];
          end
        end
        default: begin
          state_q <= ST_INIT;
        end
      endcase
    end
  end

  assign rd_data   = rd_data_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_jtvigil_obj_linebuf.sv
// Self-checking bench for jtvigil_obj_linebuf: directed scenarios plus random traffic
// compared every cycle against an array-level model of the two line banks.
module tb_jtvigil_obj_linebuf;

`ifdef JTVIGIL_OBJLB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       LHBL    = 1'b0;
  logic       flip    = 1'b0;
  logic       we      = 1'b0;
  logic       rd      = 1'b0;
  logic [8:0] wr_addr = 9'h000;
  logic [8:0] rd_addr = 9'h000;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] rd_data;
  logic       init_done;

  int n_checks = 0;
  int n_fail   = 0;

  jtvigil_obj_linebuf dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .LHBL      (LHBL),
    .flip      (flip),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .we        (we),
    .rd_addr   (rd_addr),
    .rd        (rd),
    .rd_data   (rd_data),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // Reference model: two banks of pixels, which one is being shown, and a pending erase
  logic [7:0] m_bank [2][512];
  bit         m_own  [2][512];
  bit         m_done = 1'b0;
  int         m_cnt  = 0;
  bit         m_wb   = 1'b0;
  bit         m_lh   = 1'b0;
  logic [7:0] m_rd   = 8'h00;
  bit         m_pv   = 1'b0;
  logic [8:0] m_pa   = 9'h000;
  bit         m_pb   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [8:0] a;
    bit         show;
    bit         draw;
    logic [7:0] nrd;
    if (!rst_n) begin
      m_done = 1'b0; m_cnt = 0; m_wb = 1'b0; m_lh = 1'b0; m_rd = 8'h00; m_pv = 1'b0;
    end else if (!m_done) begin
      for (int b = 0; b < 2; b++) begin
        m_bank[b][m_cnt] = 8'h00;
        m_own[b][m_cnt]  = 1'b0;
      end
      m_cnt++;
      if (m_cnt == 512) begin
        m_done = 1'b1;
        m_cnt  = 0;
      end
      m_lh = LHBL;
      m_pv = 1'b0;
    end else begin
      a    = flip ? ~rd_addr : rd_addr;
      show = !m_wb;
      nrd  = rd ? m_bank[show][a] : m_rd;
      draw = we && (wr_data[3:0] != 4'h0);
      if (m_pv && (m_pb == m_wb)) draw = 1'b0;
      if (PRIO && m_own[m_wb][wr_addr]) draw = 1'b0;
      if (m_pv) begin
        m_bank[m_pb][m_pa] = 8'h00;
        m_own[m_pb][m_pa]  = 1'b0;
      end
      if (draw) begin
        m_bank[m_wb][wr_addr] = wr_data;
        m_own[m_wb][wr_addr]  = 1'b1;
      end
      m_pv = rd; m_pa = a; m_pb = show;
      if (LHBL && !m_lh) m_wb = !m_wb;
      m_lh = LHBL;
      m_rd = nrd;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_eq("rd_data", 32'(rd_data), 32'(m_rd));
    check_eq("init_done", 32'(init_done), 32'(m_done));
  endtask

  task automatic swap();
    LHBL = 1'b0; tick();
    LHBL = 1'b1; tick();
  endtask

  task automatic wr(input logic [8:0] a, input logic [7:0] d);
    wr_addr = a; wr_data = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rd_px(input logic [8:0] a, input logic [7:0] exp, input string tag);
    rd_addr = a; rd = 1'b1;
    tick();
    rd = 1'b0;
    check_eq(tag, 32'(rd_data), 32'(exp));
  endtask

  function automatic logic [8:0] rand_addr();
    logic [8:0] r;
    r = 9'($urandom_range(0, 15));
    if ($urandom_range(0, 1) == 1) r = ~r;
    if ($urandom_range(0, 7) == 0) r = 9'($urandom);
    return r;
  endfunction

  initial begin
    int first;

    // Reset, then sweep with reads strobed throughout
    tick(); tick();
    check_eq("rst_init_done", 32'(init_done), 32'h0);
    check_eq("rst_rd_data", 32'(rd_data), 32'h00);
    rst_n = 1'b1; rd = 1'b1; first = 0;
    for (int i = 1; i <= 600; i++) begin
      rd_addr = 9'($urandom);
      tick();
      check_eq("init_rd_zero", 32'(rd_data), 32'h00);
      if (init_done && first == 0) first = i;
    end
    rd = 1'b0;
    check_eq("sweep_len", 32'(first), 32'd512);

    // Line A: opaque and transparent pixel, then erase-after-read
    wr(9'h100, 8'h35);
    wr(9'h101, 8'h20);
    swap();
    rd_px(9'h100, 8'h35, "lineA_opaque");
    rd_px(9'h101, 8'h00, "lineA_transparent");
    swap(); swap();
    rd_px(9'h100, 8'h00, "lineA_erased");

    // Flipped read address
    wr(9'h0FE, 8'h47);
    swap();
    flip = 1'b1;
    rd_px(9'h101, 8'h47, "flip_read");
    flip = 1'b0;

    // Two opaque writes to one location in a line
    wr(9'h050, 8'h12);
    wr(9'h050, 8'h9A);
    swap();
    rd_px(9'h050, PRIO ? 8'h12 : 8'h9A, "overlap_winner");

    // Swap coinciding with a read and a write
    wr(9'h010, 8'h77);
    swap();
    LHBL = 1'b0; tick();
    LHBL = 1'b1; rd = 1'b1; rd_addr = 9'h010; we = 1'b1; wr_addr = 9'h011; wr_data = 8'h5B;
    tick();
    rd = 1'b0; we = 1'b0;
    check_eq("swap_rd_old_bank", 32'(rd_data), 32'h77);
    tick();
    rd_px(9'h011, 8'h5B, "swap_wr_new_bank");
    swap();
    rd_px(9'h010, 8'h00, "swap_rd_erased");

    // Reset mid-line while pixels are pending in both banks
    wr(9'h020, 8'hC3);
    wr(9'h021, 8'hD4);
    swap();
    wr(9'h022, 8'hE5);
    LHBL = 1'b0; rst_n = 1'b0;
    tick();
    check_eq("midrst_init_done", 32'(init_done), 32'h0);
    rst_n = 1'b1; first = 0;
    for (int i = 1; i <= 600 && first == 0; i++) begin
      tick();
      if (init_done) first = i;
    end
    check_eq("midrst_sweep_len", 32'(first), 32'd512);
    rd_px(9'h020, 8'h00, "midrst_bankA_020");
    rd_px(9'h022, 8'h00, "midrst_bankA_022");
    swap();
    rd_px(9'h021, 8'h00, "midrst_bankB_021");
    rd_px(9'h022, 8'h00, "midrst_bankB_022");

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) LHBL = ~LHBL;
      we      = 1'($urandom_range(0, 1));
      wr_addr = rand_addr();
      wr_data = 8'($urandom);
      if ($urandom_range(0, 3) == 0) wr_data[3:0] = 4'h0;
      rd      = 1'($urandom_range(0, 1));
      rd_addr = rand_addr();
      if ($urandom_range(0, 63) == 0) flip = ~flip;
      tick();
    end
    we = 1'b0; rd = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
